// File: rtl/sargantana_icache_pkg.sv
// Shared geometry defaults and flush-engine state encoding for the I-cache storage array.
package sargantana_icache_pkg;

    localparam int ICACHE_N_WAYS = 4;
    localparam int ICACHE_N_SETS = 64;
    localparam int ICACHE_IDX_W  = $clog2(ICACHE_N_SETS);
    localparam int ICACHE_LINE_W = 128;
    localparam int ICACHE_TAG_W  = 20;

    typedef enum logic [1:0] {
        FL_IDLE,
        FL_FLUSH,
        FL_DONE
    } icache_flush_state_t;

endpackage

// File: rtl/sargantana_icache_way_sram.sv
// One cache way: single-port synchronous tag+line array with a registered read port.
// Only the read register is reset; the storage itself stays uninitialised like an SRAM macro.
module sargantana_icache_way_sram #(
    parameter int N_SETS = 64,
    parameter int LINE_W = 128,
    parameter int TAG_W  = 20,
    localparam int IDX_W = $clog2(N_SETS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              we,
    input  logic [IDX_W-1:0]  idx,
    input  logic [TAG_W-1:0]  tag,
    input  logic [LINE_W-1:0] line,
    output logic [TAG_W-1:0]  tag_q,
    output logic [LINE_W-1:0] line_q
);

    logic [TAG_W-1:0]  tag_mem  [N_SETS];
    logic [LINE_W-1:0] line_mem [N_SETS];

    always_ff @(posedge clk) begin
        if (en && we) begin
            tag_mem[idx]  <= tag;
            line_mem[idx] <= line;
        end
    end

    // read stage: the register holds its value until the next granted read
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_q  <= '0;
            line_q <= '0;
        end else if (en && !we) begin
            tag_q  <= tag_mem[idx];
            line_q <= line_mem[idx];
        end
    end

endmodule

// File: rtl/sargantana_icache_mem_array.sv
// N-way I-cache storage: per-way SRAMs for tag/line, flop-based valid bits, registered 1-cycle
// read, per-way write, and a set-walking flush engine (flush > write > read on the single port).
module sargantana_icache_mem_array
    import sargantana_icache_pkg::*;
#(
    parameter int N_WAYS = ICACHE_N_WAYS,
    parameter int N_SETS = ICACHE_N_SETS,
    parameter int LINE_W = ICACHE_LINE_W,
    parameter int TAG_W  = ICACHE_TAG_W,
    localparam int IDX_W = $clog2(N_SETS)
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     rd_req_i,
    input  logic [IDX_W-1:0]         rd_idx_i,
    output logic                     rd_gnt_o,
    output logic                     rd_valid_o,
    output logic [N_WAYS*TAG_W-1:0]  tag_way_o,
    output logic [N_WAYS*LINE_W-1:0] line_way_o,
    output logic [N_WAYS-1:0]        vbit_way_o,
    input  logic                     wr_req_i,
    input  logic [N_WAYS-1:0]        wr_way_i,
    input  logic [IDX_W-1:0]         wr_idx_i,
    input  logic [TAG_W-1:0]         wr_tag_i,
    input  logic [LINE_W-1:0]        wr_line_i,
    input  logic                     wr_vbit_i,
    output logic                     wr_gnt_o,
    input  logic                     flush_req_i,
    output logic                     busy_o,
    output logic                     flush_done_o
);

    icache_flush_state_t             state;
    logic [IDX_W-1:0]                cnt;
    logic                            wr_gnt;
    logic                            rd_gnt;
    logic [IDX_W-1:0]                idx_p0;
    logic                            vld_p1;
    logic [N_WAYS-1:0]               vbit_p1;
    logic [N_WAYS-1:0][N_SETS-1:0]   vbits;

    assign wr_gnt = wr_req_i & (state == FL_IDLE) & ~flush_req_i;
    assign rd_gnt = rd_req_i & (state == FL_IDLE) & ~flush_req_i & ~wr_req_i;
    assign wr_gnt_o = wr_gnt;
    assign rd_gnt_o = rd_gnt;
    assign idx_p0 = wr_gnt ? wr_idx_i : rd_idx_i;

    // flush engine: one set per cycle, busy/done registered alongside the state
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state        <= FL_IDLE;
            cnt          <= '0;
            busy_o       <= 1'b0;
            flush_done_o <= 1'b0;
        end else begin
            flush_done_o <= 1'b0;
            case (state)
                FL_IDLE: begin
                    if (flush_req_i) begin
                        state  <= FL_FLUSH;
                        cnt    <= '0;
                        busy_o <= 1'b1;
                    end
                end
                FL_FLUSH: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == IDX_W'(N_SETS - 1)) begin
                        state        <= FL_DONE;
                        busy_o       <= 1'b0;
                        flush_done_o <= 1'b1;
                    end
                end
                FL_DONE: state <= FL_IDLE;
                default: state <= FL_IDLE;
            endcase
        end
    end

    // valid bits live in flops so a whole set across all ways clears in one cycle
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vbits <= '0;
        end else if (state == FL_FLUSH) begin
            for (int w = 0; w < N_WAYS; w++) vbits[w][cnt] <= 1'b0;
        end else if (wr_gnt) begin
            for (int w = 0; w < N_WAYS; w++) begin
                if (wr_way_i[w]) vbits[w][wr_idx_i] <= wr_vbit_i;
            end
        end
    end

    // p0 -> p1: read index sampled on grant, results presented the following cycle
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vld_p1  <= 1'b0;
            vbit_p1 <= '0;
        end else begin
            vld_p1 <= rd_gnt;
            if (rd_gnt) begin
                for (int w = 0; w < N_WAYS; w++) vbit_p1[w] <= vbits[w][rd_idx_i];
            end
        end
    end

    assign rd_valid_o = vld_p1;
    assign vbit_way_o = vbit_p1;

    for (genvar w = 0; w < N_WAYS; w++) begin : g_way
        sargantana_icache_way_sram #(
            .N_SETS (N_SETS),
            .LINE_W (LINE_W),
            .TAG_W  (TAG_W)
        ) u_sram (
            .clk    (clk_i),
            .rst    (rst_i),
            .en     (rd_gnt | (wr_gnt & wr_way_i[w])),
            .we     (wr_gnt),
            .idx    (idx_p0),
            .tag    (wr_tag_i),
            .line   (wr_line_i),
            .tag_q  (tag_way_o[w*TAG_W +: TAG_W]),
            .line_q (line_way_o[w*LINE_W +: LINE_W])
        );
    end

endmodule

// File: tb/tb_sargantana_icache_mem_array.sv
// Directed bench for the I-cache storage array: default 4x64 geometry plus a 1-way/2-set build.
module tb_sargantana_icache_mem_array;

    logic         clk = 1'b0;
    logic         rst;
    always #5 clk = ~clk;

    // default geometry: 4 ways, 64 sets, 128-bit lines, 20-bit tags
    logic         rd_req, rd_gnt, rd_valid;
    logic [5:0]   rd_idx;
    logic [79:0]  tag_way;
    logic [511:0] line_way;
    logic [3:0]   vbit_way;
    logic         wr_req, wr_gnt, wr_vbit;
    logic [3:0]   wr_way;
    logic [5:0]   wr_idx;
    logic [19:0]  wr_tag;
    logic [127:0] wr_line;
    logic         flush_req, busy, flush_done;

    // small geometry: 1 way, 2 sets, 8-bit lines, 4-bit tags
    logic         b_rd_req, b_rd_gnt, b_rd_valid;
    logic [0:0]   b_rd_idx;
    logic [3:0]   b_tag_way;
    logic [7:0]   b_line_way;
    logic [0:0]   b_vbit_way;
    logic         b_wr_req, b_wr_gnt, b_wr_vbit;
    logic [0:0]   b_wr_way;
    logic [0:0]   b_wr_idx;
    logic [3:0]   b_wr_tag;
    logic [7:0]   b_wr_line;
    logic         b_flush_req, b_busy, b_flush_done;

    int n_vec = 0;
    int n_err = 0;

    sargantana_icache_mem_array dut (
        .clk_i(clk), .rst_i(rst),
        .rd_req_i(rd_req), .rd_idx_i(rd_idx), .rd_gnt_o(rd_gnt), .rd_valid_o(rd_valid),
        .tag_way_o(tag_way), .line_way_o(line_way), .vbit_way_o(vbit_way),
        .wr_req_i(wr_req), .wr_way_i(wr_way), .wr_idx_i(wr_idx), .wr_tag_i(wr_tag),
        .wr_line_i(wr_line), .wr_vbit_i(wr_vbit), .wr_gnt_o(wr_gnt),
        .flush_req_i(flush_req), .busy_o(busy), .flush_done_o(flush_done)
    );

    sargantana_icache_mem_array #(.N_WAYS(1), .N_SETS(2), .LINE_W(8), .TAG_W(4)) dut_b (
        .clk_i(clk), .rst_i(rst),
        .rd_req_i(b_rd_req), .rd_idx_i(b_rd_idx), .rd_gnt_o(b_rd_gnt), .rd_valid_o(b_rd_valid),
        .tag_way_o(b_tag_way), .line_way_o(b_line_way), .vbit_way_o(b_vbit_way),
        .wr_req_i(b_wr_req), .wr_way_i(b_wr_way), .wr_idx_i(b_wr_idx), .wr_tag_i(b_wr_tag),
        .wr_line_i(b_wr_line), .wr_vbit_i(b_wr_vbit), .wr_gnt_o(b_wr_gnt),
        .flush_req_i(b_flush_req), .busy_o(b_busy), .flush_done_o(b_flush_done)
    );

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [5:0] idx, input logic [3:0] way,
                            input logic [19:0] tag, input logic [127:0] line, input logic vb);
        wr_req = 1'b1; wr_idx = idx; wr_way = way; wr_tag = tag; wr_line = line; wr_vbit = vb;
        tick();
        wr_req = 1'b0;
    endtask

    task automatic do_read(input logic [5:0] idx);
        rd_req = 1'b1; rd_idx = idx;
        tick();
        rd_req = 1'b0;
    endtask

    localparam logic [127:0] LINE_A = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    localparam logic [127:0] LINE_B = 128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555;

    int busy_cnt, done_at, gnt_seen, done_seen;

    initial begin
        rst = 1'b1;
        rd_req = 0; rd_idx = 0; wr_req = 0; wr_way = 0; wr_idx = 0; wr_tag = 0; wr_line = 0;
        wr_vbit = 0; flush_req = 0;
        b_rd_req = 0; b_rd_idx = 0; b_wr_req = 0; b_wr_way = 0; b_wr_idx = 0; b_wr_tag = 0;
        b_wr_line = 0; b_wr_vbit = 0; b_flush_req = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_rd_valid", rd_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", flush_done, 0);
        check("rst_tag", tag_way, 0);
        check("rst_line", line_way, 0);
        check("rst_vbit", vbit_way, 0);
        rst = 1'b0;

        // read after reset: every valid bit is clear
        rd_req = 1'b1; rd_idx = 6'd17;
        #1 check("rd_gnt_idle", rd_gnt, 1);
        tick();
        rd_req = 1'b0;
        check("rst_read_valid", rd_valid, 1);
        check("rst_read_vbit", vbit_way, 0);

        // write way 2 idx 5, read it back
        wr_req = 1'b1; wr_way = 4'b0100; wr_idx = 6'd5; wr_tag = 20'hABCDE; wr_line = LINE_A;
        wr_vbit = 1'b1;
        #1 check("wr_gnt", wr_gnt, 1);
        tick();
        wr_req = 1'b0;
        do_read(6'd5);
        check("w2_valid", rd_valid, 1);
        check("w2_tag", tag_way[40 +: 20], 20'hABCDE);
        check("w2_line", line_way[256 +: 128], LINE_A);
        check("w2_vbit", vbit_way, 4'b0100);
        tick();
        check("hold_valid", rd_valid, 0);
        check("hold_tag", tag_way[40 +: 20], 20'hABCDE);

        // simultaneous read and multi-hot write: write wins, retried read sees it
        rd_req = 1'b1; rd_idx = 6'd9;
        wr_req = 1'b1; wr_way = 4'b1001; wr_idx = 6'd9; wr_tag = 20'h12345; wr_line = LINE_B;
        wr_vbit = 1'b1;
        #1;
        check("both_wr_gnt", wr_gnt, 1);
        check("both_rd_gnt", rd_gnt, 0);
        tick();
        wr_req = 1'b0;
        #1 check("retry_rd_gnt", rd_gnt, 1);
        tick();
        rd_req = 1'b0;
        check("retry_tag0", tag_way[0 +: 20], 20'h12345);
        check("retry_tag3", tag_way[60 +: 20], 20'h12345);
        check("retry_line3", line_way[384 +: 128], LINE_B);
        check("retry_vbit", vbit_way, 4'b1001);

        // read granted, then same-idx write the next cycle must not disturb presented data
        do_read(6'd5);
        wr_req = 1'b1; wr_way = 4'b0100; wr_idx = 6'd5; wr_tag = 20'h11111; wr_vbit = 1'b0;
        check("rw_tag_pres", tag_way[40 +: 20], 20'hABCDE);
        check("rw_vbit_pres", vbit_way, 4'b0100);
        tick();
        wr_req = 1'b0;
        check("rw_tag_hold", tag_way[40 +: 20], 20'hABCDE);
        do_read(6'd5);
        check("rw_tag_new", tag_way[40 +: 20], 20'h11111);
        check("rw_vbit_new", vbit_way, 4'b0000);

        // zero-hot write is granted but changes nothing
        wr_req = 1'b1; wr_way = 4'b0000; wr_idx = 6'd7; wr_vbit = 1'b1;
        #1 check("zero_way_gnt", wr_gnt, 1);
        tick();
        wr_req = 1'b0;
        do_read(6'd7);
        check("zero_way_vbit", vbit_way, 4'b0000);

        // fill every set in every way, then flush
        for (int i = 0; i < 64; i++) do_write(6'(i), 4'b1111, 20'(i), LINE_A, 1'b1);
        do_read(6'd63);
        check("fill_vbit63", vbit_way, 4'b1111);
        check("fill_tag63", tag_way[20 +: 20], 20'd63);

        flush_req = 1'b1;
        wr_req = 1'b1; wr_way = 4'b1111; wr_idx = 6'd0; wr_vbit = 1'b1;
        #1 check("flush_beats_wr", wr_gnt, 0);
        tick();
        flush_req = 1'b0; wr_req = 1'b0;
        rd_req = 1'b1; rd_idx = 6'd0;
        busy_cnt = 0; done_at = 0; gnt_seen = 0;
        for (int c = 1; c <= 200; c++) begin
            if (busy) busy_cnt++;
            if (rd_gnt || wr_gnt) gnt_seen = 1;
            if (flush_done) begin
                done_at = c;
                if (busy) busy_cnt = busy_cnt + 1000;
                break;
            end
            tick();
        end
        rd_req = 1'b0;
        check("flush_busy_cycles", busy_cnt, 64);
        check("flush_done_cycle", done_at, 65);
        check("flush_no_gnt", gnt_seen, 0);
        tick();
        check("done_one_cycle", flush_done, 0);
        do_read(6'd0);
        check("flush_vbit0", vbit_way, 0);
        do_read(6'd31);
        check("flush_vbit31", vbit_way, 0);
        do_read(6'd63);
        check("flush_vbit63", vbit_way, 0);

        // reset in the middle of a flush
        do_write(6'd60, 4'b1111, 20'h0F0F0, LINE_B, 1'b1);
        do_read(6'd60);
        check("pre_rst_vbit", vbit_way, 4'b1111);
        flush_req = 1'b1;
        tick();
        flush_req = 1'b0;
        repeat (19) tick();
        check("flush20_busy", busy, 1);
        #2 rst = 1'b1;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_vbit", vbit_way, 0);
        check("midrst_valid", rd_valid, 0);
        check("midrst_tag", tag_way, 0);
        tick();
        rst = 1'b0;
        done_seen = 0;
        for (int c = 0; c < 80; c++) begin
            if (flush_done || busy) done_seen = 1;
            tick();
        end
        check("midrst_no_done", done_seen, 0);
        do_read(6'd60);
        check("midrst_vbit60", vbit_way, 0);

        // 1-way, 2-set build
        b_wr_req = 1'b1; b_wr_way = 1'b1; b_wr_idx = 1'b1; b_wr_tag = 4'hA; b_wr_line = 8'h5A;
        b_wr_vbit = 1'b1;
        #1 check("b_wr_gnt", b_wr_gnt, 1);
        tick();
        b_wr_req = 1'b0;
        b_rd_req = 1'b1; b_rd_idx = 1'b1;
        tick();
        b_rd_req = 1'b0;
        check("b_rd_valid", b_rd_valid, 1);
        check("b_tag", b_tag_way, 4'hA);
        check("b_line", b_line_way, 8'h5A);
        check("b_vbit", b_vbit_way, 1'b1);

        b_flush_req = 1'b1;
        tick();
        busy_cnt = 0; done_at = 0;
        for (int c = 1; c <= 20; c++) begin
            if (b_busy) busy_cnt++;
            if (b_flush_done) begin
                done_at = c;
                break;
            end
            tick();
        end
        check("b_flush_latency", done_at, 3);
        check("b_busy_cycles", busy_cnt, 2);
        tick();
        check("b_idle_busy", b_busy, 0);
        check("b_idle_done", b_flush_done, 0);
        tick();
        b_flush_req = 1'b0;
        check("b_retrigger", b_busy, 1);
        repeat (2) tick();
        check("b_second_done", b_flush_done, 1);
        tick();
        b_rd_req = 1'b1; b_rd_idx = 1'b1;
        tick();
        b_rd_req = 1'b0;
        check("b_flush_vbit", b_vbit_way, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
